// File: rtl/acortex_lb_pkg.sv
// rtl/acortex_lb_pkg.sv - shared types and constants for the ACORTEX local bus master
package acortex_lb_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lb_state_t;

  // Cycles spent in WAIT before the transaction is declared dead
  localparam int LB_TOUT_CYC_DEF = 200;

  // Read data returned to the host when the responder never answers
  localparam logic [15:0] LB_ERR_CODE = 16'hdead;

  // Block select field of the LB address; the remaining bits are the block offset
  localparam int LB_BLK_MSB = 11;
  localparam int LB_BLK_LSB = 8;

endpackage

// File: rtl/acortex_lb_master.sv
// rtl/acortex_lb_master.sv - single-outstanding local bus initiator with timeout
module acortex_lb_master
  import acortex_lb_pkg::*;
#(
  parameter int P_LB_ADDR_W = 12,
  parameter int P_LB_DATA_W = 16,
  parameter int P_TOUT_W    = 8,
  parameter int P_TOUT_CYC  = LB_TOUT_CYC_DEF
) (
  input  logic                   clk_ir,
  input  logic                   rst_il,
  input  logic                   host_req_ih,
  input  logic                   host_rd_nwr_ih,
  input  logic [P_LB_ADDR_W-1:0] host_addr_id,
  input  logic [P_LB_DATA_W-1:0] host_wr_data_id,
  output logic                   host_ready_oh,
  output logic                   host_rsp_valid_oh,
  output logic [P_LB_DATA_W-1:0] host_rsp_data_od,
  output logic                   host_rsp_err_oh,
  output logic                   lb_rd_en_oh,
  output logic                   lb_wr_en_oh,
  output logic [P_LB_ADDR_W-1:0] lb_addr_od,
  output logic [P_LB_DATA_W-1:0] lb_wr_data_od,
  input  logic                   lb_rd_valid_id,
  input  logic [P_LB_DATA_W-1:0] lb_rd_data_id,
  input  logic                   lb_wr_valid_id
);

  lb_state_t             state, state_nxt;
  logic                  rd_nwr, rd_nwr_nxt;
  logic [P_TOUT_W-1:0]   cnt, cnt_nxt;
  logic                  ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic                  rd_en_nxt, wr_en_nxt;
  logic [P_LB_DATA_W-1:0] rsp_data_nxt, wr_data_nxt;
  logic [P_LB_ADDR_W-1:0] addr_nxt;
  logic                  expired;

  // Last WAIT cycle before giving up on the responder
  assign expired = (cnt == P_TOUT_W'(P_TOUT_CYC - 1));

  // State register
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_nxt     = state;
    ready_nxt     = host_ready_oh;
    rd_en_nxt     = 1'b0;
    wr_en_nxt     = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = host_rsp_data_od;
    rsp_err_nxt   = host_rsp_err_oh;
    addr_nxt      = lb_addr_od;
    wr_data_nxt   = lb_wr_data_od;
    rd_nwr_nxt    = rd_nwr;
    cnt_nxt       = cnt;
    unique case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (host_req_ih) begin
          rd_nwr_nxt  = host_rd_nwr_ih;
          addr_nxt    = host_addr_id;
          wr_data_nxt = host_wr_data_id;
          rd_en_nxt   = host_rd_nwr_ih;
          wr_en_nxt   = !host_rd_nwr_ih;
          ready_nxt   = 1'b0;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Enable drops here: the responder decodes on the enable level
        cnt_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        // A matching valid beats a simultaneous expiry
        if (rd_nwr && lb_rd_valid_id) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = lb_rd_data_id;
          rsp_err_nxt   = 1'b0;
          state_nxt     = ST_RESP;
        end else if (!rd_nwr && lb_wr_valid_id) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = '0;
          rsp_err_nxt   = 1'b0;
          state_nxt     = ST_RESP;
        end else if (expired) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = P_LB_DATA_W'(LB_ERR_CODE);
          rsp_err_nxt   = 1'b1;
          state_nxt     = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      host_ready_oh     <= 1'b1;
      host_rsp_valid_oh <= 1'b0;
      host_rsp_data_od  <= '0;
      host_rsp_err_oh   <= 1'b0;
      lb_rd_en_oh       <= 1'b0;
      lb_wr_en_oh       <= 1'b0;
      lb_addr_od        <= '0;
      lb_wr_data_od     <= '0;
      rd_nwr            <= 1'b0;
      cnt               <= '0;
    end else begin
      host_ready_oh     <= ready_nxt;
      host_rsp_valid_oh <= rsp_valid_nxt;
      host_rsp_data_od  <= rsp_data_nxt;
      host_rsp_err_oh   <= rsp_err_nxt;
      lb_rd_en_oh       <= rd_en_nxt;
      lb_wr_en_oh       <= wr_en_nxt;
      lb_addr_od        <= addr_nxt;
      lb_wr_data_od     <= wr_data_nxt;
      rd_nwr            <= rd_nwr_nxt;
      cnt               <= cnt_nxt;
    end
  end

endmodule
